single_priority_encoder: RTL and testbench

Registered 4-input priority encoder with MSB priority. It reports the highest-priority asserted request as a 2-bit code, where input bit 3 maps to code 0 and input bit 0 maps to code 3. It also flags whether any request is present. It sits between raw request lines and downstream arbitration/selection logic, giving a clean clocked code with a fixed one-cycle latency.

---
 rtl/prio_enc_pkg.sv | 8 +
 rtl/prio_enc_core.sv | 25 ++
 rtl/single_priority_encoder.sv | 38 +++
 tb/tb_single_priority_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared constants for the registered priority encoder.
package prio_enc_pkg;

  localparam int PRIO_N_DEFAULT  = 4;
  localparam int PRIO_OW_DEFAULT = 2;
  localparam int PRIO_RST_CODE   = 0;

endpackage

// File: rtl/prio_enc_core.sv
// Combinational MSB-first priority scan: highest set bit k yields code (N-1)-k.
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int N  = PRIO_N_DEFAULT,
  parameter int OW = $clog2(N)
) (
  input  logic [N-1:0]  A,
  output logic [OW-1:0] code_next,
  output logic          any_next
);

  // Descending scan; once any_next is set, lower bits are ignored.
  always_comb begin
    code_next = '0;
    any_next  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (A[i] && !any_next) begin
        code_next = OW'(N - 1 - i);
        any_next  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/single_priority_encoder.sv
// Registered N-input priority encoder with capture enable and async active-low reset.
module single_priority_encoder
  import prio_enc_pkg::*;
#(
  parameter int N  = PRIO_N_DEFAULT,
  parameter int OW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  A,
  input  logic          en,
  output logic [OW-1:0] O,
  output logic          valid
);

  logic [OW-1:0] code_d, O_q;
  logic          any_d, valid_q;

  prio_enc_core #(.N(N), .OW(OW)) u_core (
    .A         (A),
    .code_next (code_d),
    .any_next  (any_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O_q     <= OW'(PRIO_RST_CODE);
      valid_q <= 1'b0;
    end else if (en) begin
      O_q     <= code_d;
      valid_q <= any_d;
    end
  end

  assign O     = O_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_single_priority_encoder.sv
// Scoreboard bench for single_priority_encoder (N=4).
module tb_single_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] A = '0;
  logic       en = 1'b0;
  logic [1:0] O;
  logic       valid;

  int nvec = 0;
  int nmis = 0;

  logic [2:0] sb[$];
  logic [1:0] m_o = 2'd0;
  logic       m_v = 1'b0;

  single_priority_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .en    (en),
    .O     (O),
    .valid (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Ascending scan, later hits overwrite: leaves the highest set bit.
  function automatic logic [1:0] enc(input logic [3:0] a);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 0; i < 4; i++)
      if (a[i]) c = 2'(3 - i);
    return c;
  endfunction

  // Drive one vector before an edge, push its expectation, land #1 after the edge.
  task automatic drive(input logic [3:0] a, input logic e);
    @(negedge clk);
    A  = a;
    en = e;
    if (e) begin
      m_o = enc(a);
      m_v = |a;
    end
    sb.push_back({m_o, m_v});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    rst_n = 1'b0;
    A = 4'b1000;
    en = 1'b1;
    m_o = 2'd0;
    m_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({O, valid} !== {m_o, m_v}) begin
      nmis++;
      $display("FAIL reset_hold: got O=%b valid=%b, want O=%b valid=%b", O, valid, m_o, m_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1000, 1'b1);
    exp = sb.pop_front();
    nvec++;
    if ({O, valid} !== exp) begin
      nmis++;
      $display("FAIL reset_release: got %b%b, want %b", O, valid, exp);
    end
  endtask

  task automatic test_onehot();
    logic [3:0] v[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [2:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(v[i], 1'b1);
      exp = sb.pop_front();
      nvec++;
      if ({O, valid} !== exp) begin
        nmis++;
        $display("FAIL onehot A=%b: got %b%b, want %b", v[i], O, valid, exp);
      end
    end
  endtask

  task automatic test_multibit();
    logic [3:0] v[5] = '{4'b1100, 4'b0111, 4'b0011, 4'b1001, 4'b1111};
    logic [2:0] exp;
    for (int i = 0; i < 5; i++) begin
      drive(v[i], 1'b1);
      exp = sb.pop_front();
      nvec++;
      if ({O, valid} !== exp) begin
        nmis++;
        $display("FAIL multibit A=%b: got %b%b, want %b", v[i], O, valid, exp);
      end
    end
  endtask

  task automatic test_zero();
    logic [2:0] exp;
    drive(4'b0000, 1'b1);
    exp = sb.pop_front();
    nvec++;
    if ({O, valid} !== exp || exp !== 3'b000) begin
      nmis++;
      $display("FAIL zero: got %b%b, want %b", O, valid, exp);
    end
  endtask

  task automatic test_enable_hold();
    logic [2:0] exp;
    drive(4'b0010, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drive(4'b1000, 1'b0);
      exp = sb.pop_front();
      nvec++;
      if ({O, valid} !== exp) begin
        nmis++;
        $display("FAIL en_hold cyc%0d: got %b%b, want %b", i, O, valid, exp);
      end
    end
    drive(4'b1000, 1'b1);
    exp = sb.pop_front();
    nvec++;
    if ({O, valid} !== exp) begin
      nmis++;
      $display("FAIL en_resume: got %b%b, want %b", O, valid, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] exp;
    drive(4'b0001, 1'b1);
    exp = sb.pop_front();
    nvec++;
    if ({O, valid} !== exp) begin
      nmis++;
      $display("FAIL pre_async: got %b%b, want %b", O, valid, exp);
    end
    #2;
    rst_n = 1'b0;
    m_o = 2'd0;
    m_v = 1'b0;
    sb.delete();
    #1;
    nvec++;
    if ({O, valid} !== {m_o, m_v}) begin
      nmis++;
      $display("FAIL async_reset: got O=%b valid=%b, want O=%b valid=%b", O, valid, m_o, m_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0100, 1'b1);
    exp = sb.pop_front();
    nvec++;
    if ({O, valid} !== exp) begin
      nmis++;
      $display("FAIL post_async: got %b%b, want %b", O, valid, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    logic       e;
    logic [2:0] exp;
    for (int i = 0; i < 32; i++) begin
      a = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) != 0);
      drive(a, e);
      exp = sb.pop_front();
      nvec++;
      if ({O, valid} !== exp) begin
        nmis++;
        $display("FAIL b2b A=%b en=%b: got %b%b, want %b", a, e, O, valid, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_multibit();
    test_zero();
    test_enable_hold();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
